// File: rtl/pipe_skid_buf_if.sv
// Handshake bundle for pipe_skid_buf: upstream and downstream valid/ready plus occupancy.
// The flush signal exists only when PIPE_SKID_FLUSH_EN is defined.
interface pipe_skid_buf_if #(
    parameter int WIDTH = 2
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       count;
`ifdef PIPE_SKID_FLUSH_EN
    logic             flush;
`endif

    modport master (
        output in_data, in_valid, out_ready,
`ifdef PIPE_SKID_FLUSH_EN
        output flush,
`endif
        input  in_ready, out_data, out_valid, count
    );

    modport slave (
        input  in_data, in_valid, out_ready,
`ifdef PIPE_SKID_FLUSH_EN
        input  flush,
`endif
        output in_ready, out_data, out_valid, count
    );
endinterface

// File: rtl/pipe_skid_buf.sv
// Two-entry valid/ready stage with a skid register; upstream ready depends only on state.
// Optional synchronous flush is enabled with the PIPE_SKID_FLUSH_EN macro.
module pipe_skid_buf #(
    parameter int WIDTH = 2
) (
    input  logic                clk,
    input  logic                reset,
    pipe_skid_buf_if.slave      bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             xfer_in, xfer_out;

    assign bus.out_data  = main_q;
    assign bus.out_valid = (state_q != EMPTY);
    assign bus.in_ready  = reset & (state_q != FULL);
    assign bus.count     = state_q;

    assign xfer_in  = bus.in_valid & bus.in_ready;
    assign xfer_out = bus.out_valid & bus.out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (xfer_in) begin
                    main_d  = bus.in_data;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (xfer_in && xfer_out) begin
                    main_d = bus.in_data;
                end else if (xfer_in) begin
                    skid_d  = bus.in_data;
                    state_d = FULL;
                end else if (xfer_out) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (xfer_out) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
`ifdef PIPE_SKID_FLUSH_EN
        // Flush only drops occupancy; stored words stay in place but become invalid.
        if (bus.flush) begin
            state_d = EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end
endmodule

// File: doc/pipe_skid_buf.md
# pipe_skid_buf

Two-entry valid/ready pipeline stage for the pipelined datapath, the stall-aware counterpart to the plain enabled pipeline registers. It accepts a WIDTH-bit word from an upstream stage and presents it to a downstream stage. When the downstream stage stalls, it absorbs one extra in-flight word in a skid register. Upstream ready depends only on internal state, so downstream stalls never create a combinational ready path across stages.

## Interface
Reset is synchronous and active-low; clock is `clk`, reset is `reset`.

Parameters:
- WIDTH, 2, payload width in bits (≥1)

Ports:
- clk  in  1  rising-edge clock; all state changes on posedge
- reset  in  1  synchronous, active-low
- in_data  in  WIDTH  upstream payload
- in_valid  in  1  upstream word present
- in_ready  out  1  stage can accept a word this cycle
- out_data  out  WIDTH  downstream payload (main register)
- out_valid  out  1  out_data holds a valid word
- out_ready  in  1  downstream accepts this cycle
- count  out  2  occupancy: 0, 1 or 2
- flush  in  1  present only with PIPE_SKID_FLUSH_EN

## Operation
- Transfer-in (TI) = in_valid & in_ready; transfer-out (TO) = out_valid & out_ready.
- Storage: main register (drives out_data) and skid register. State encodes occupancy: EMPTY(0), ONE(1), FULL(2); count = state.
- Combinational outputs:
  - out_valid = (state != EMPTY)
  - in_ready = reset & (state != FULL)
  - No combinational path from out_ready or in_valid to any output.
- State transitions on each posedge:
  - EMPTY, TI: main <= in_data; go to ONE.
  - EMPTY, no TI: remain EMPTY.
  - ONE, TI & TO: main <= in_data; remain ONE.
  - ONE, TI only: skid <= in_data; go to FULL.
  - ONE, TO only: go to EMPTY.
  - ONE, neither: hold.
  - FULL, TO: main <= skid; go to ONE. TI is impossible because in_ready=0.
  - FULL, no TO: hold; in_data is ignored.
- Word order is strictly FIFO. No word is dropped or duplicated.
- Registers not written hold their value. Skid contents are don't-care outside FULL, but are not cleared.

## Timing
- Reset (reset=0 at a posedge): state=EMPTY, main=0, skid=0.
  - Outputs then: out_data=0, out_valid=0, count=0.
  - in_ready=0 while reset is low; in_ready=1 in the first cycle after release.
  - Reset mid-operation discards all held words and overrides every other input.
- Latency: a word accepted at edge N is on out_data with out_valid=1 from edge N until the edge at which it is consumed.
- Throughput: one word per cycle sustained when out_ready is held high.
- Stall response:
  - out_ready dropping in ONE with in_valid=1 fills the skid at the next edge.
  - in_ready falls in the same cycle FULL is entered.
  - in_ready rises the cycle after the first TO from FULL.
- Simultaneous TI & TO in ONE keeps count=1 and loads the new word.
- out_data and out_valid stay stable while out_valid=1 and out_ready=0.

## Configuration
- PIPE_SKID_FLUSH_EN defined:
  - The `flush` port exists.
  - flush=1 at a posedge (with reset=1) forces state=EMPTY. Any TI in that cycle is discarded.
  - Main and skid registers are unchanged; out_valid=0 and in_ready=1 next cycle.
  - Priority order: reset > flush > normal operation.
- PIPE_SKID_FLUSH_EN undefined: no `flush` port; behaviour exactly as above without flush.

## Test plan
- Reset: hold reset=0 for 3 cycles with in_valid=1, in_data=2'b11 -> out_valid=0, out_data=0, count=0, in_ready=0; after release, in_ready=1, count=0.
- Streaming: out_ready=1, feed 1,2,3,0 back-to-back -> outputs 1,2,3,0, each one cycle after acceptance; count stays 1; in_ready never drops.
- Stall fill: accept 1, then out_ready=0 and offer 2, then 3 -> count=2, in_ready=0, out_data=1 held, 3 not accepted. Raise out_ready -> 1, 2, 3 out in order; in_ready=1 the cycle after 1 leaves.
- Simultaneous: in ONE holding 2, TI of 3 with TO -> next cycle out_data=3, count=1.
- Reset mid-operation: in FULL holding 1,2, pulse reset=0 for one cycle -> count=0, out_valid=0, out_data=0; next word 3 emerges alone.
- Flush (PIPE_SKID_FLUSH_EN): in FULL, flush=1 with in_valid=1 and data 3 -> count=0, out_valid=0, 3 dropped; next word 1 emerges with count=1.
